// File: rtl/tmnt_pkg.sv
// Shared types and memory-map defaults for the ROM/SDRAM read-port arbiter.
package tmnt_pkg;

  typedef enum logic [1:0] {
    ID_NONE = 2'd0,
    ID_CPU  = 2'd1,
    ID_TILE = 2'd2,
    ID_SPR  = 2'd3
  } port_id_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned           MEM_AW        = 22;
  localparam logic [MEM_AW-1:0]     CPU_BASE_DEF  = 22'h000000;
  localparam logic [MEM_AW-1:0]     TILE_BASE_DEF = 22'h040000;
  localparam logic [MEM_AW-1:0]     SPR_BASE_DEF  = 22'h100000;
  localparam int unsigned           WAIT_MAX_DEF  = 4;

endpackage

// File: rtl/rom_req_slot.sv
// One-deep request buffer: pend flag plus latched address for one requester.
module rom_req_slot #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         strobe,
  input  logic [W-1:0] addr,
  input  logic         take,
  output logic         pend,
  output logic [W-1:0] pend_addr
);

  // A strobe in the same cycle as the grant re-queues the port with the new address.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= 1'b0;
      pend_addr <= '0;
    end else if (strobe) begin
      pend      <= 1'b1;
      pend_addr <= addr;
    end else if (take) begin
      pend      <= 1'b0;
    end
  end

endmodule

// File: rtl/gfx_rom_arbiter.sv
// Shares one 32-bit memory read port between 68k program fetch, tile GFX and sprite GFX.
module gfx_rom_arbiter
  import tmnt_pkg::*;
#(
  parameter int unsigned     AW        = 22,
  parameter logic [AW-1:0]   CPU_BASE  = AW'(CPU_BASE_DEF),
  parameter logic [AW-1:0]   TILE_BASE = AW'(TILE_BASE_DEF),
  parameter logic [AW-1:0]   SPR_BASE  = AW'(SPR_BASE_DEF),
  parameter int unsigned     WAIT_MAX  = WAIT_MAX_DEF
) (
  input  logic          clk_main,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [17:0]   cpu_addr,
  output logic [15:0]   cpu_data,
  output logic          cpu_ack,
  input  logic          tile_req,
  input  logic [19:0]   tile_addr,
  output logic [31:0]   tile_data,
  output logic          tile_ack,
  input  logic          spr_req,
  input  logic [19:0]   spr_addr,
  output logic [31:0]   spr_data,
  output logic          spr_ack,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rdy,
  input  logic [31:0]   mem_dout,
  output logic [1:0]    grant_id
);

  logic        cpu_pend, tile_pend, spr_pend;
  logic [17:0] cpu_pa;
  logic [19:0] tile_pa, spr_pa;
  logic        take_cpu, take_tile, take_spr;

  rom_req_slot #(.W(18)) u_cpu_slot (
    .clk(clk_main), .reset(reset), .strobe(cpu_req), .addr(cpu_addr),
    .take(take_cpu), .pend(cpu_pend), .pend_addr(cpu_pa)
  );
  rom_req_slot #(.W(20)) u_tile_slot (
    .clk(clk_main), .reset(reset), .strobe(tile_req), .addr(tile_addr),
    .take(take_tile), .pend(tile_pend), .pend_addr(tile_pa)
  );
  rom_req_slot #(.W(20)) u_spr_slot (
    .clk(clk_main), .reset(reset), .strobe(spr_req), .addr(spr_addr),
    .take(take_spr), .pend(spr_pend), .pend_addr(spr_pa)
  );

  logic [AW-1:0] cpu_maddr, tile_maddr, spr_maddr;
  assign cpu_maddr  = CPU_BASE  + AW'(cpu_pa[17:1]);
  assign tile_maddr = TILE_BASE + AW'(tile_pa);
  assign spr_maddr  = SPR_BASE  + AW'(spr_pa);

  arb_state_e    state_q, state_d;
  port_id_e      owner_q, owner_d;
  logic          cpu_lsb_q, cpu_lsb_d;
  logic [3:0]    starve_q;
  logic          cpu_due;
  logic          mem_req_d;
  logic [AW-1:0] mem_addr_d;
  logic          cpu_ack_d, tile_ack_d, spr_ack_d;
  logic [15:0]   cpu_data_d;
  logic [31:0]   tile_data_d, spr_data_d;

  assign cpu_due  = cpu_pend && (starve_q == 4'(WAIT_MAX));
  assign grant_id = owner_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cpu_lsb_d   = cpu_lsb_q;
    mem_req_d   = mem_req;
    mem_addr_d  = mem_addr;
    take_cpu    = 1'b0;
    take_tile   = 1'b0;
    take_spr    = 1'b0;
    cpu_ack_d   = 1'b0;
    tile_ack_d  = 1'b0;
    spr_ack_d   = 1'b0;
    cpu_data_d  = cpu_data;
    tile_data_d = tile_data;
    spr_data_d  = spr_data;
    case (state_q)
      ST_IDLE: begin
        if (cpu_due)        take_cpu  = 1'b1;
        else if (tile_pend) take_tile = 1'b1;
        else if (spr_pend)  take_spr  = 1'b1;
        else if (cpu_pend)  take_cpu  = 1'b1;
        if (take_cpu) begin
          owner_d    = ID_CPU;
          mem_addr_d = cpu_maddr;
          cpu_lsb_d  = cpu_pa[0];
        end else if (take_tile) begin
          owner_d    = ID_TILE;
          mem_addr_d = tile_maddr;
        end else if (take_spr) begin
          owner_d    = ID_SPR;
          mem_addr_d = spr_maddr;
        end
        if (take_cpu || take_tile || take_spr) begin
          mem_req_d = 1'b1;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_rdy) begin
          mem_req_d = 1'b0;
          owner_d   = ID_NONE;
          state_d   = ST_IDLE;
          case (owner_q)
            ID_CPU: begin
              cpu_ack_d  = 1'b1;
              cpu_data_d = cpu_lsb_q ? mem_dout[31:16] : mem_dout[15:0];
            end
            ID_TILE: begin
              tile_ack_d  = 1'b1;
              tile_data_d = mem_dout;
            end
            ID_SPR: begin
              spr_ack_d  = 1'b1;
              spr_data_d = mem_dout;
            end
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_main) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= ID_NONE;
      cpu_lsb_q <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      cpu_ack   <= 1'b0;
      tile_ack  <= 1'b0;
      spr_ack   <= 1'b0;
      cpu_data  <= '0;
      tile_data <= '0;
      spr_data  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cpu_lsb_q <= cpu_lsb_d;
      mem_req   <= mem_req_d;
      mem_addr  <= mem_addr_d;
      cpu_ack   <= cpu_ack_d;
      tile_ack  <= tile_ack_d;
      spr_ack   <= spr_ack_d;
      cpu_data  <= cpu_data_d;
      tile_data <= tile_data_d;
      spr_data  <= spr_data_d;
    end
  end

  // Counts video grants that overtook a waiting cpu; saturates so cpu_due stays asserted.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      starve_q <= '0;
    end else if (take_cpu || !cpu_pend) begin
      starve_q <= '0;
    end else if ((take_tile || take_spr) && (starve_q != 4'(WAIT_MAX))) begin
      starve_q <= starve_q + 4'd1;
    end
  end

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// Scoreboard bench for gfx_rom_arbiter: directed strobes, memory responder, grant/ack monitor.
`timescale 1ns/1ps
module tb_gfx_rom_arbiter;

  typedef struct {
    logic [1:0]  id;
    logic [21:0] addr;
  } grant_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } ack_t;

  logic        clk_main = 1'b0;
  logic        reset    = 1'b1;
  logic        cpu_req  = 1'b0;
  logic [17:0] cpu_addr = '0;
  logic        tile_req = 1'b0;
  logic [19:0] tile_addr = '0;
  logic        spr_req  = 1'b0;
  logic [19:0] spr_addr = '0;
  logic        mem_rdy  = 1'b0;
  logic [31:0] mem_dout = '0;

  logic [15:0] cpu_data;
  logic        cpu_ack;
  logic [31:0] tile_data;
  logic        tile_ack;
  logic [31:0] spr_data;
  logic        spr_ack;
  logic        mem_req;
  logic [21:0] mem_addr;
  logic [1:0]  grant_id;

  logic [15:0] w_cpu_data;
  logic        w_cpu_ack;
  logic [31:0] w_tile_data;
  logic        w_tile_ack;
  logic [31:0] w_spr_data;
  logic        w_spr_ack;
  logic        w_mem_req;
  logic [21:0] w_mem_addr;
  logic [1:0]  w_grant_id;

  grant_t      exp_grant[$];
  ack_t        exp_ack[$];
  logic [31:0] rsp_q[$];

  int          n_tests      = 0;
  int          n_fail       = 0;
  int          grant_count  = 0;
  int          cyc          = 0;
  int          last_ack_cyc = 0;
  int unsigned rsp_lat      = 1;
  int unsigned inject_cnt   = 0;
  bit          chk_wrap     = 1'b0;

  gfx_rom_arbiter #(.AW(22), .WAIT_MAX(4)) dut (
    .clk_main(clk_main), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
    .tile_req(tile_req), .tile_addr(tile_addr), .tile_data(tile_data), .tile_ack(tile_ack),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_data(spr_data), .spr_ack(spr_ack),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_dout(mem_dout),
    .grant_id(grant_id)
  );

  // Same stimulus, tile region based at the top of memory so the address sum wraps.
  gfx_rom_arbiter #(.TILE_BASE(22'h3FFFFF)) dut_wrap (
    .clk_main(clk_main), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(w_cpu_data), .cpu_ack(w_cpu_ack),
    .tile_req(tile_req), .tile_addr(tile_addr), .tile_data(w_tile_data), .tile_ack(w_tile_ack),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_data(w_spr_data), .spr_ack(w_spr_ack),
    .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_rdy(mem_rdy), .mem_dout(mem_dout),
    .grant_id(w_grant_id)
  );

  initial forever #5 clk_main = ~clk_main;

  always @(posedge clk_main) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got no completion, expected one within bound", name);
  endtask

  task automatic tick();
    @(posedge clk_main);
    #1;
  endtask

  task automatic expect_access(input logic [1:0] id, input logic [21:0] addr,
                               input logic [31:0] dout, input logic [31:0] ack_data);
    grant_t g;
    ack_t   a;
    g.id   = id;
    g.addr = addr;
    a.id   = id;
    a.data = ack_data;
    exp_grant.push_back(g);
    exp_ack.push_back(a);
    rsp_q.push_back(dout);
  endtask

  task automatic wait_grants(input int target, input string name);
    int k;
    k = 0;
    while (grant_count < target && k < 300) begin
      tick();
      k++;
    end
    if (grant_count < target) fail_timeout(name);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((exp_ack.size() != 0 || mem_req) && k < 400) begin
      tick();
      k++;
    end
    if (exp_ack.size() != 0 || mem_req) fail_timeout(name);
    tick();
  endtask

  task automatic responder_loop();
    int unsigned wcnt;
    int unsigned seen;
    wcnt = 0;
    seen = 0;
    forever begin
      @(posedge clk_main);
      #2;
      mem_rdy = 1'b0;
      if (inject_cnt != seen) begin
        seen++;
        mem_rdy  = 1'b1;
        mem_dout = 32'h12345678;
      end else if (mem_req) begin
        if (wcnt >= rsp_lat) begin
          mem_rdy  = 1'b1;
          mem_dout = (rsp_q.size() != 0) ? rsp_q.pop_front() : 32'hDEADBEEF;
          wcnt     = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  endtask

  task automatic monitor_loop();
    logic        req_prev;
    logic [21:0] cur_addr;
    grant_t      g;
    ack_t        a;
    logic [1:0]  aid;
    logic [31:0] adat;
    int          nack;
    req_prev = 1'b0;
    cur_addr = '0;
    forever begin
      @(negedge clk_main);
      if (mem_req && !req_prev) begin
        grant_count++;
        cur_addr = mem_addr;
        if (exp_grant.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_grant: got grant_id %0d addr %h, expected no grant", grant_id, mem_addr);
        end else begin
          g = exp_grant.pop_front();
          check("grant_id", 32'(grant_id), 32'(g.id));
          check("mem_addr", 32'(mem_addr), 32'(g.addr));
        end
        if (chk_wrap) check("wrap_addr", 32'(w_mem_addr), 32'h000FFFFE);
      end else if (mem_req) begin
        check("mem_addr_stable", 32'(mem_addr), 32'(cur_addr));
      end
      req_prev = mem_req;

      nack = int'(cpu_ack) + int'(tile_ack) + int'(spr_ack);
      if (nack > 1) begin
        n_tests++;
        n_fail++;
        $display("FAIL multi_ack: got %0d acks, expected at most 1", nack);
      end else if (nack == 1) begin
        last_ack_cyc = cyc;
        aid  = cpu_ack ? 2'd1 : (tile_ack ? 2'd2 : 2'd3);
        adat = cpu_ack ? {16'h0, cpu_data} : (tile_ack ? tile_data : spr_data);
        if (exp_ack.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ack: got port %0d data %h, expected no ack", aid, adat);
        end else begin
          a = exp_ack.pop_front();
          check("ack_port", 32'(aid), 32'(a.id));
          check("ack_data", adat, a.data);
        end
      end
    end
  endtask

  initial begin
    int s_cyc;
    int base;
    grant_t g;

    fork
      monitor_loop();
      responder_loop();
    join_none

    reset = 1'b1;
    repeat (3) tick();
    check("rst_mem_req",  32'(mem_req), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_acks",     32'({cpu_ack, tile_ack, spr_ack}), 32'h0);
    check("rst_data",     32'(cpu_data) | tile_data | spr_data, 32'h0);
    check("rst_starve",   32'(dut.starve_q), 32'h0);
    reset = 1'b0;
    tick();

    // single cpu read, upper half selected by address lsb
    rsp_lat = 1;
    expect_access(2'd1, 22'h000001, 32'hAAAA5555, 32'h0000AAAA);
    cpu_addr = 18'h00003;
    cpu_req  = 1'b1;
    s_cyc    = cyc;
    tick();
    cpu_req = 1'b0;
    wait_idle("cpu_single");
    check("cpu_latency", 32'(last_ack_cyc - s_cyc), 32'd4);

    // three simultaneous strobes: tile, spr, cpu
    rsp_lat = 0;
    expect_access(2'd2, 22'h040123, 32'h11112222, 32'h11112222);
    expect_access(2'd3, 22'h100456, 32'h33334444, 32'h33334444);
    expect_access(2'd1, 22'h000008, 32'h55556666, 32'h00006666);
    tile_addr = 20'h00123; spr_addr = 20'h00456; cpu_addr = 18'h00010;
    tile_req = 1'b1; spr_req = 1'b1; cpu_req = 1'b1;
    tick();
    tile_req = 1'b0; spr_req = 1'b0; cpu_req = 1'b0;
    wait_idle("priority");

    // cpu starved by continuous tile traffic
    rsp_lat = 2;
    base = grant_count;
    expect_access(2'd2, 22'h040001, 32'h00000001, 32'h00000001);
    expect_access(2'd2, 22'h040002, 32'h00000002, 32'h00000002);
    expect_access(2'd2, 22'h040003, 32'h00000003, 32'h00000003);
    expect_access(2'd2, 22'h040004, 32'h00000004, 32'h00000004);
    expect_access(2'd1, 22'h000080, 32'hCAFE0123, 32'h0000CAFE);
    expect_access(2'd2, 22'h040005, 32'h00000005, 32'h00000005);
    cpu_addr = 18'h00101; tile_addr = 20'h00001;
    cpu_req = 1'b1; tile_req = 1'b1;
    tick();
    cpu_req = 1'b0; tile_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wait_grants(base + i, "starve_grant");
      if (i == 4) check("starve_sat", 32'(dut.starve_q), 32'd4);
      tile_addr = 20'(i + 1);
      tile_req  = 1'b1;
      tick();
      tile_req  = 1'b0;
    end
    wait_grants(base + 5, "starve_cpu");
    check("starve_clear", 32'(dut.starve_q), 32'd0);
    wait_idle("starve");

    // spr re-strobed while its own access is in flight
    rsp_lat = 2;
    base = grant_count;
    expect_access(2'd3, 22'h100010, 32'h01020304, 32'h01020304);
    expect_access(2'd3, 22'h100020, 32'h05060708, 32'h05060708);
    spr_addr = 20'h00010; spr_req = 1'b1;
    tick();
    spr_req = 1'b0;
    wait_grants(base + 1, "requeue_grant");
    spr_addr = 20'h00020; spr_req = 1'b1;
    tick();
    spr_req = 1'b0;
    wait_idle("requeue");

    // spr strobed twice while pending behind a tile access: last address, one ack
    rsp_lat = 3;
    expect_access(2'd2, 22'h040007, 32'hA1A1A1A1, 32'hA1A1A1A1);
    expect_access(2'd3, 22'h100040, 32'hB2B2B2B2, 32'hB2B2B2B2);
    tile_addr = 20'h00007; tile_req = 1'b1;
    tick();
    tile_req = 1'b0;
    spr_addr = 20'h00030; spr_req = 1'b1;
    tick();
    spr_addr = 20'h00040;
    tick();
    spr_req = 1'b0;
    wait_idle("overwrite");

    // reset while BUSY, then a late mem_rdy that must be ignored
    rsp_lat = 50;
    base = grant_count;
    g.id = 2'd1;
    g.addr = 22'h000002;
    exp_grant.push_back(g);
    cpu_addr = 18'h00004; cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    wait_grants(base + 1, "reset_grant");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    inject_cnt++;
    tick();
    tick();
    check("rbusy_mem_req",  32'(mem_req), 32'h0);
    check("rbusy_mem_addr", 32'(mem_addr), 32'h0);
    check("rbusy_grant_id", 32'(grant_id), 32'h0);
    check("rbusy_acks",     32'({cpu_ack, tile_ack, spr_ack}), 32'h0);
    check("rbusy_cpu_data", 32'(cpu_data), 32'h0);
    check("rbusy_tile_data", tile_data, 32'h0);
    check("rbusy_spr_data", spr_data, 32'h0);
    repeat (3) tick();

    // tile address sum wrapping modulo 2^AW (checked on the second instance)
    rsp_lat  = 1;
    chk_wrap = 1'b1;
    expect_access(2'd2, 22'h13FFFF, 32'h0BADF00D, 32'h0BADF00D);
    tile_addr = 20'hFFFFF; tile_req = 1'b1;
    tick();
    tile_req = 1'b0;
    wait_idle("wrap");
    chk_wrap = 1'b0;

    check("grants_left", 32'(exp_grant.size()), 32'h0);
    check("acks_left",   32'(exp_ack.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
